inst_fetch_unit_nway: RTL and testbench
=======================================

// Module: inst_fetch_unit_nway
// PURPOSE
//  Parametrised per-way instruction fetch unit for the N-way front end; one instance per fetch way.
//  Issues fetch requests to the I-memory port and tracks in-flight requests with an address queue,
//  so every returned instruction carries the address it was fetched from.
//  Buffers returned instructions for the decoder and tags each with a way-interleaved packet ID.
//  Supports flush: buffered data is discarded and late responses are dropped.
// PARAMETERS
//  ADDR_W     32  instruction address width
//  DATA_W     32  instruction word width
//  DEPTH      4   max (in-flight + buffered + to-drop) entries; power of 2, >=2
//  NUM_WAYS   2   fetch ways in the front end; pID stride
//  PID_W      2   packet ID width
//  PID_RESET  0   pID reset value (= way index of this instance)
// PORTS
//  clk          in   1       clock
//  reset_n      in   1       asynchronous, active-low reset
//  flush_i      in   1       discard buffered and in-flight fetches
//  valid_i      in   1       upstream PC valid
//  instAddr_i   in   ADDR_W  PC to fetch
//  ready_o      out  1       credit available; PC accepted when valid_i & ready_o
//  request_o    out  1       memory request strobe (= valid_i & ready_o)
//  instAddr_fetch_o out ADDR_W memory request address (= instAddr_i)
//  dataOk_i     in   1       memory response valid; responses return in request order
//  inst_fetch_i in   DATA_W  memory response data
//  valid_o      out  1       instruction available to decoder
//  ready_i      in   1       decoder accepts; pop when valid_o & ready_i
//  inst_o       out  DATA_W  instruction
//  instAddr_o   out  ADDR_W  address of inst_o
//  pID_o        out  PID_W   packet ID of current output
// BEHAVIOUR
//  - Reset: all queues empty, inflight=0, drop_cnt=0, valid_o=0, ready_o=0 for one cycle only if flush_i,
//    else 1; inst_o/instAddr_o=0; pID_o=PID_RESET.
//  - Credit: ready_o = !flush_i & (inflight + drop_cnt + out_count < DEPTH); combinational, no valid_i dependency.
//  - Issue: on request_o, push instAddr_i into addr queue (inflight+1).
//  - Response, drop_cnt==0 & inflight>0: pop addr queue, push {addr, inst_fetch_i} into out queue.
//    Credit reservation guarantees out queue never overflows.
//  - Response, drop_cnt>0: discard, drop_cnt-1. Response with inflight=0 and drop_cnt=0: ignored.
//  - Output: valid_o = out queue non-empty; inst_o/instAddr_o from head. Minimum latency dataOk_i -> valid_o: 1 cycle.
//  - Simultaneous push/pop on a full out queue is legal: count unchanged.
//  - pID_o += NUM_WAYS (mod 2^PID_W) on each output handshake; unchanged on flush.
//  - Flush (single cycle, priority over all): out queue and addr queue cleared;
//    drop_cnt <= drop_cnt + inflight - (dataOk_i ? 1 : 0) (saturating at 0); inflight <= 0;
//    no issue and no pop that cycle; valid_o=0 from next cycle.
//  - Issue during drop is permitted; new responses follow the dropped ones in order.
//  - Counters are sized $clog2(DEPTH+1); invariant inflight+drop_cnt+out_count <= DEPTH
//    (assertion under simulation).
// CONFIGURATION
//  IFU_BYPASS_EN defined: when out queue is empty, drop_cnt==0 and a response arrives, the response is
//    presented on valid_o/inst_o/instAddr_o in the same cycle. If ready_i, it is consumed without a push.
//    Otherwise it is pushed as normal. pID_o advances identically.
//  Undefined: 1-cycle registered path only; no combinational dataOk_i -> valid_o path.
// STRUCTURE
//  - ifu_pkg: ifu_entry_t {addr, inst} struct; IFU_CNT_W function of DEPTH.
//  - Sub-module ifu_sync_fifo #(WIDTH, DEPTH): push/pop/clear, full/empty/count.
//    Instantiated twice: addr queue (ADDR_W) and out queue (ifu_entry_t).
// TESTING
//  1 Reset, valid_i=1 -> ready_o=1, request_o=1, valid_o=0, pID_o=PID_RESET.
//  2 Issue 0x100,0x104; dataOk 2 cycles later with 0xAA,0xBB; ready_i=1
//    -> outputs (0xAA,0x100,pID 0), then (0xBB,0x104,pID 2).
//  3 ready_i=0, issue 4 PCs and return 4 responses -> ready_o=0 after 4th issue;
//    drain in order; ready_o=1 after first pop.
//  4 Issue 3 PCs, flush_i with 0 responses back -> valid_o=0; next 3 dataOk dropped;
//    new PC 0x200 returned as 0x200/data.
//  5 Flush same cycle as dataOk with inflight=2 -> drop_cnt=1; exactly one later response dropped.
//  6 IFU_BYPASS_EN, empty queue, ready_i=1, dataOk_i=1 -> valid_o=1 same cycle; queue count stays 0.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and sizing helpers for the per-way instruction fetch unit.
// Optional same-cycle response bypass is enabled by defining IFU_BYPASS_EN.
package ifu_pkg;

  localparam int IFU_ADDR_W = 32;
  localparam int IFU_DATA_W = 32;

  // Output queue entry at the default 32/32 widths; the fetch unit declares the same layout at its own widths.
  typedef struct packed {
    logic [IFU_ADDR_W-1:0] addr;
    logic [IFU_DATA_W-1:0] inst;
  } ifu_entry_t;

  // Counter width able to hold every value from 0 to depth inclusive.
  function automatic int ifu_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ifu_sync_fifo.sv
// Small synchronous FIFO with combinational head read, used as the fetch address queue and output queue.
// Clear has priority over push and pop. A push and a pop in the same cycle on a full FIFO is legal.
module ifu_sync_fifo
  import ifu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            pop_data,
  output logic                        full,
  output logic                        empty,
  output logic [ifu_cnt_w(DEPTH)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = ifu_cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop & ~empty & ~clear;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push  = push & (~full | do_pop) & ~clear;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;

endmodule

// File: rtl/inst_fetch_unit_nway.sv
// Per-way instruction fetch unit: issues fetches on credit, pairs responses with their addresses,
// buffers them for the decoder with way-interleaved packet IDs, and drops responses orphaned by a flush.
// Define IFU_BYPASS_EN to present a response on an empty output queue in the same cycle it arrives.
module inst_fetch_unit_nway
  import ifu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4,
  parameter int NUM_WAYS  = 2,
  parameter int PID_W     = 2,
  parameter int PID_RESET = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] instAddr_i,
  output logic              ready_o,
  output logic              request_o,
  output logic [ADDR_W-1:0] instAddr_fetch_o,
  input  logic              dataOk_i,
  input  logic [DATA_W-1:0] inst_fetch_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] instAddr_o,
  output logic [PID_W-1:0]  pID_o
);

  localparam int CNT_W = ifu_cnt_w(DEPTH);
  localparam int SUM_W = CNT_W + 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] inst;
  } entry_t;

  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [PID_W-1:0] pid_q, pid_d;
  logic [SUM_W-1:0] credit_sum, flush_sum;

  logic              issue, resp_take, out_push, out_pop, handshake;
  logic [ADDR_W-1:0] addr_head;
  logic              addr_full, addr_empty;
  logic [CNT_W-1:0]  addr_count;
  entry_t            out_entry, out_head;
  logic              out_full, out_empty;
  logic [CNT_W-1:0]  out_count;

  ifu_sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_addr_q (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (flush_i),
    .push      (issue),
    .push_data (instAddr_i),
    .pop       (resp_take),
    .pop_data  (addr_head),
    .full      (addr_full),
    .empty     (addr_empty),
    .count     (addr_count)
  );

  ifu_sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_out_q (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (flush_i),
    .push      (out_push),
    .push_data (out_entry),
    .pop       (out_pop),
    .pop_data  (out_head),
    .full      (out_full),
    .empty     (out_empty),
    .count     (out_count)
  );

  always_comb begin
    // Every issued fetch reserves an output slot, so the out queue cannot overflow.
    credit_sum       = SUM_W'(inflight_q) + SUM_W'(drop_cnt_q) + SUM_W'(out_count);
    ready_o          = ~flush_i & (credit_sum < SUM_W'(DEPTH));
    issue            = valid_i & ready_o;
    request_o        = issue;
    instAddr_fetch_o = instAddr_i;

    resp_take        = dataOk_i & ~flush_i & (drop_cnt_q == '0) & (inflight_q != '0);
    out_entry.addr   = addr_head;
    out_entry.inst   = inst_fetch_i;

    valid_o    = ~out_empty;
    inst_o     = '0;
    instAddr_o = '0;
    if (!out_empty) begin
      inst_o     = out_head.inst;
      instAddr_o = out_head.addr;
    end
`ifdef IFU_BYPASS_EN
    else if (resp_take) begin
      valid_o    = 1'b1;
      inst_o     = inst_fetch_i;
      instAddr_o = addr_head;
    end
`endif
    pID_o     = pid_q;
    handshake = valid_o & ready_i & ~flush_i;
    out_pop   = handshake & ~out_empty;
    // A bypassed response consumed straight away never enters the queue.
    out_push  = resp_take & ~(handshake & out_empty);
  end

  always_comb begin
    inflight_d = inflight_q;
    drop_cnt_d = drop_cnt_q;
    pid_d      = pid_q;
    flush_sum  = SUM_W'(drop_cnt_q) + SUM_W'(inflight_q);
    if (flush_i) begin
      if (dataOk_i && flush_sum != '0) flush_sum = flush_sum - 1'b1;
      drop_cnt_d = CNT_W'(flush_sum);
      inflight_d = '0;
    end else begin
      if (issue && !resp_take)      inflight_d = inflight_q + 1'b1;
      else if (!issue && resp_take) inflight_d = inflight_q - 1'b1;
      if (dataOk_i && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - 1'b1;
      if (handshake) pid_d = pid_q + PID_W'(NUM_WAYS);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= '0;
      drop_cnt_q <= '0;
      pid_q      <= PID_W'(PID_RESET);
    end else begin
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      pid_q      <= pid_d;
    end
  end

`ifndef SYNTHESIS
  a_credit_bound: assert property (@(posedge clk) disable iff (!reset_n)
    credit_sum <= SUM_W'(DEPTH));
  a_addr_tracks_inflight: assert property (@(posedge clk) disable iff (!reset_n)
    addr_count == inflight_q);
  a_no_addr_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(issue && addr_full));
  a_no_addr_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(resp_take && addr_empty));
  a_no_out_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(out_push && out_full && !out_pop));
`endif

endmodule

// File: tb/tb_inst_fetch_unit_nway.sv
// Directed self-checking bench for inst_fetch_unit_nway (DEPTH=4, NUM_WAYS=2, PID_W=2, PID_RESET=0).
module tb_inst_fetch_unit_nway;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush_i, valid_i, ready_o, request_o, dataOk_i, valid_o, ready_i;
  logic [31:0] instAddr_i, instAddr_fetch_o, inst_fetch_i, inst_o, instAddr_o;
  logic [1:0]  pID_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_fetch_unit_nway #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(4), .NUM_WAYS(2), .PID_W(2), .PID_RESET(0)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .flush_i          (flush_i),
    .valid_i          (valid_i),
    .instAddr_i       (instAddr_i),
    .ready_o          (ready_o),
    .request_o        (request_o),
    .instAddr_fetch_o (instAddr_fetch_o),
    .dataOk_i         (dataOk_i),
    .inst_fetch_i     (inst_fetch_i),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .inst_o           (inst_o),
    .instAddr_o       (instAddr_o),
    .pID_o            (pID_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; instAddr_i = '0;
    dataOk_i = 1'b0; inst_fetch_i = '0; ready_i = 1'b0;

    // 1: reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_pid", pID_o, 0);
    chk("rst_inst_o", inst_o, 0);
    chk("rst_addr_o", instAddr_o, 0);
    @(negedge clk); reset_n = 1'b1; valid_i = 1'b1; instAddr_i = 32'h100; #1;
    chk("t1_ready_o", ready_o, 1);
    chk("t1_request_o", request_o, 1);
    chk("t1_fetch_addr", instAddr_fetch_o, 32'h100);
    chk("t1_valid_o", valid_o, 0);
    $display("txn t1: reset and first issue 0x100");

    // 2: two fetches, responses two cycles later, decoder always ready
    @(negedge clk); instAddr_i = 32'h104; ready_i = 1'b1; #1;
    chk("t2_ready_o", ready_o, 1);
    @(negedge clk); valid_i = 1'b0; dataOk_i = 1'b1; inst_fetch_i = 32'hAA; #1;
    chk("t2_no_comb_path", valid_o, 0);
    @(negedge clk); inst_fetch_i = 32'hBB; #1;
    chk("t2_valid0", valid_o, 1);
    chk("t2_inst0", inst_o, 32'hAA);
    chk("t2_addr0", instAddr_o, 32'h100);
    chk("t2_pid0", pID_o, 0);
    $display("txn t2: out inst=%0h addr=%0h pid=%0d", inst_o, instAddr_o, pID_o);
    @(negedge clk); dataOk_i = 1'b0; #1;
    chk("t2_valid1", valid_o, 1);
    chk("t2_inst1", inst_o, 32'hBB);
    chk("t2_addr1", instAddr_o, 32'h104);
    chk("t2_pid1", pID_o, 2);
    $display("txn t2: out inst=%0h addr=%0h pid=%0d", inst_o, instAddr_o, pID_o);
    @(negedge clk); #1;
    chk("t2_empty", valid_o, 0);
    chk("t2_pid_wrap", pID_o, 0);

    // 3: fill all credits with the decoder stalled, then drain in order
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); valid_i = 1'b1; instAddr_i = 32'h300 + 32'(4 * i); #1;
      chk("t3_ready_pre", ready_o, 1);
      $display("txn t3: issue addr=%0h", instAddr_i);
    end
    @(negedge clk); valid_i = 1'b0; #1;
    chk("t3_ready_full", ready_o, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); dataOk_i = 1'b1; inst_fetch_i = 32'hD0 + 32'(i); #1;
      chk("t3_ready_hold", ready_o, 0);
    end
    @(negedge clk); dataOk_i = 1'b0; ready_i = 1'b1; #1;
    chk("t3_ready_before_pop", ready_o, 0);
    chk("t3_valid", valid_o, 1);
    chk("t3_inst0", inst_o, 32'hD0);
    chk("t3_addr0", instAddr_o, 32'h300);
    chk("t3_pid0", pID_o, 0);
    $display("txn t3: out inst=%0h addr=%0h pid=%0d", inst_o, instAddr_o, pID_o);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); #1;
      chk("t3_ready_after_pop", ready_o, 1);
      chk("t3_inst", inst_o, 32'hD0 + 32'(i));
      chk("t3_addr", instAddr_o, 32'h300 + 32'(4 * i));
      chk("t3_pid", pID_o, 64'((2 * i) % 4));
      $display("txn t3: out inst=%0h addr=%0h pid=%0d", inst_o, instAddr_o, pID_o);
    end
    @(negedge clk); ready_i = 1'b0; #1;
    chk("t3_drained", valid_o, 0);

    // 4: flush with three fetches outstanding, all three responses dropped
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); valid_i = 1'b1; instAddr_i = 32'h400 + 32'(4 * i);
    end
    @(negedge clk); valid_i = 1'b0; flush_i = 1'b1; #1;
    chk("t4_ready_in_flush", ready_o, 0);
    @(negedge clk); flush_i = 1'b0; valid_i = 1'b1; instAddr_i = 32'h200; #1;
    chk("t4_valid_after_flush", valid_o, 0);
    chk("t4_ready_during_drop", ready_o, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); valid_i = 1'b0; dataOk_i = 1'b1; inst_fetch_i = 32'hDEAD0 + 32'(i); #1;
      chk("t4_dropped", valid_o, 0);
    end
    @(negedge clk); inst_fetch_i = 32'h2222; #1;
    chk("t4_dropped_last", valid_o, 0);
    @(negedge clk); dataOk_i = 1'b0; ready_i = 1'b1; #1;
    chk("t4_valid", valid_o, 1);
    chk("t4_inst", inst_o, 32'h2222);
    chk("t4_addr", instAddr_o, 32'h200);
    chk("t4_pid", pID_o, 0);
    $display("txn t4: out inst=%0h addr=%0h pid=%0d", inst_o, instAddr_o, pID_o);
    @(negedge clk); ready_i = 1'b0; #1;
    chk("t4_empty", valid_o, 0);
    chk("t4_pid_next", pID_o, 2);

    // 5: flush coinciding with a response while one entry is buffered and two are in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); valid_i = 1'b1; instAddr_i = 32'h500 + 32'(4 * i);
    end
    @(negedge clk); valid_i = 1'b0; dataOk_i = 1'b1; inst_fetch_i = 32'h5000;
    @(negedge clk); dataOk_i = 1'b0; #1;
    chk("t5_buffered", valid_o, 1);
    @(negedge clk); flush_i = 1'b1; dataOk_i = 1'b1; inst_fetch_i = 32'h5555;
    @(negedge clk); flush_i = 1'b0; dataOk_i = 1'b0; #1;
    chk("t5_flushed", valid_o, 0);
    chk("t5_ready", ready_o, 1);
    chk("t5_pid_flush", pID_o, 2);
    @(negedge clk); dataOk_i = 1'b1; inst_fetch_i = 32'h6666;
    @(negedge clk); dataOk_i = 1'b0; valid_i = 1'b1; instAddr_i = 32'h600; #1;
    chk("t5_one_dropped", valid_o, 0);
    @(negedge clk); valid_i = 1'b0; dataOk_i = 1'b1; inst_fetch_i = 32'h7777;
    @(negedge clk); dataOk_i = 1'b0; ready_i = 1'b1; #1;
    chk("t5_valid", valid_o, 1);
    chk("t5_inst", inst_o, 32'h7777);
    chk("t5_addr", instAddr_o, 32'h600);
    chk("t5_pid", pID_o, 2);
    $display("txn t5: out inst=%0h addr=%0h pid=%0d", inst_o, instAddr_o, pID_o);
    @(negedge clk); ready_i = 1'b0; dataOk_i = 1'b1; inst_fetch_i = 32'h9999; #1;
    chk("t5_empty", valid_o, 0);
    @(negedge clk); dataOk_i = 1'b0; #1;
    chk("t5_stray_ignored", valid_o, 0);
    chk("t5_pid_after", pID_o, 0);

    // 6: response arriving on an empty queue with the decoder ready
    ready_i = 1'b1;
    @(negedge clk); valid_i = 1'b1; instAddr_i = 32'h700;
    @(negedge clk); valid_i = 1'b0; dataOk_i = 1'b1; inst_fetch_i = 32'h8888; #1;
`ifdef IFU_BYPASS_EN
    chk("t6_bypass_valid", valid_o, 1);
    chk("t6_bypass_inst", inst_o, 32'h8888);
    chk("t6_bypass_addr", instAddr_o, 32'h700);
    @(negedge clk); dataOk_i = 1'b0; #1;
    chk("t6_no_push", valid_o, 0);
`else
    chk("t6_same_cycle", valid_o, 0);
    @(negedge clk); dataOk_i = 1'b0; #1;
    chk("t6_valid", valid_o, 1);
    chk("t6_inst", inst_o, 32'h8888);
    chk("t6_addr", instAddr_o, 32'h700);
    @(negedge clk); #1;
    chk("t6_empty", valid_o, 0);
`endif
    chk("t6_pid", pID_o, 2);
    $display("txn t6: response 0x8888 for 0x700 delivered");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
